// File: rtl/result_display.sv
// result_display: buffers factors from the factorization core and shows them,
// one at a time, as six BCD digits for the HEX0..HEX5 seven-segment decoders.
//
// Ports
//   clk, rst            system clock (rising edge), asynchronous active-high reset
//   fact_in/fact_last   factor value and end-of-result marker from the core
//   fact_valid          fact_in/fact_last valid
//   fact_ready          buffer can accept; a transfer is fact_valid & fact_ready
//   next_in             one-cycle pulse: advance to the next factor
//   clr_in              one-cycle pulse: flush buffer and display
//   seg1..seg6          BCD digits, seg1 = ones ... seg6 = 10^5; 4'hF = overflow
//   last_out            displayed factor carries fact_last
//   empty               buffer holds no entries
//   busy                binary-to-BCD conversion in progress
//
// Configuration
//   RESULT_WRAP_EN      entries are retained and next_in cycles through them,
//                       wrapping to entry 0 after the fact_last entry (or the
//                       last written one); only clr_in frees the buffer.
//                       Undefined: next_in pops the displayed entry.

module result_display #(
   parameter int unsigned WIDTH = 20,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] fact_in,
   input  logic             fact_last,
   input  logic             fact_valid,
   output logic             fact_ready,
   input  logic             next_in,
   input  logic             clr_in,
   output logic [3:0]       seg1,
   output logic [3:0]       seg2,
   output logic [3:0]       seg3,
   output logic [3:0]       seg4,
   output logic [3:0]       seg5,
   output logic [3:0]       seg6,
   output logic             last_out,
   output logic             empty,
   output logic             busy
);

   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNTW = AW + 1;
   localparam int unsigned IW   = $clog2(WIDTH + 1);
   localparam int unsigned BCDW = 24;
   localparam int unsigned CW   = (WIDTH > 20) ? WIDTH : 20;
   localparam logic [IW-1:0] LAST_ITER = IW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;

   state_t              state;
   logic [WIDTH:0]      mem [DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [CNTW-1:0]     count;
   logic [WIDTH-1:0]    bin;
   logic [BCDW-1:0]     bcd;
   logic [IW-1:0]       iter;
   logic                cur_last;
   logic                ovf;
`ifdef RESULT_WRAP_EN
   logic                last_seen;
   logic                at_end;
`endif

   logic                full;
   logic                push;
   logic                advance;
   logic                more;
   logic [AW-1:0]       next_idx;
   logic [AW-1:0]       load_idx;
   logic [WIDTH:0]      head;
   logic                head_ovf;
   logic [BCDW-1:0]     bcd_adj;
   logic [BCDW+WIDTH-1:0] sh;
   logic [BCDW-1:0]     bcd_nx;

   assign full    = (count == CNTW'(DEPTH));
   assign push    = fact_valid && fact_ready;
   assign advance = (state == SHOW) && next_in;
   assign empty   = (count == '0);
   assign busy    = (state == CONV);

`ifdef RESULT_WRAP_EN
   // Wrap back to entry 0 after the end-of-result entry or the newest entry.
   assign at_end     = mem[rd_ptr][WIDTH] || ((CNTW'(rd_ptr) + CNTW'(1)) == count);
   assign next_idx   = at_end ? '0 : rd_ptr + AW'(1);
   assign more       = 1'b1;
   assign fact_ready = !full && !clr_in && !last_seen;
`else
   assign next_idx   = rd_ptr + AW'(1);
   assign more       = (count > CNTW'(1));
   assign fact_ready = !full && !clr_in;
`endif

   // Entry to convert: current head from IDLE, following entry from SHOW.
   assign load_idx = (state == SHOW) ? next_idx : rd_ptr;
   assign head     = mem[load_idx];
   assign head_ovf = CW'(head[WIDTH-1:0]) > CW'(999999);

   // Double-dabble step: add 3 to nibbles >= 5, then shift {bcd, bin} left.
   always_comb begin
      bcd_adj = bcd;
      for (int d = 0; d < 6; d++) begin
         if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
   end

   assign sh     = {bcd_adj, bin} << 1;
   assign bcd_nx = sh[BCDW+WIDTH-1:WIDTH];

   // Buffer storage (no reset needed; validity tracked by count).
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {fact_last, fact_in};
   end

   // Buffer pointers, conversion engine and display registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         bin      <= '0;
         bcd      <= '0;
         iter     <= '0;
         cur_last <= 1'b0;
         ovf      <= 1'b0;
         seg1     <= '0;
         seg2     <= '0;
         seg3     <= '0;
         seg4     <= '0;
         seg5     <= '0;
         seg6     <= '0;
         last_out <= 1'b0;
`ifdef RESULT_WRAP_EN
         last_seen <= 1'b0;
`endif
      end else if (clr_in) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         bin      <= '0;
         bcd      <= '0;
         iter     <= '0;
         cur_last <= 1'b0;
         ovf      <= 1'b0;
         seg1     <= '0;
         seg2     <= '0;
         seg3     <= '0;
         seg4     <= '0;
         seg5     <= '0;
         seg6     <= '0;
         last_out <= 1'b0;
`ifdef RESULT_WRAP_EN
         last_seen <= 1'b0;
`endif
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);

`ifdef RESULT_WRAP_EN
         if (push) count <= count + CNTW'(1);
         if (push && fact_last) last_seen <= 1'b1;
`else
         case ({push, advance})
            2'b10:   count <= count + CNTW'(1);
            2'b01:   count <= count - CNTW'(1);
            default: ;
         endcase
`endif

         case (state)
            IDLE: begin
               if (count != '0) begin
                  bin      <= head[WIDTH-1:0];
                  bcd      <= '0;
                  iter     <= '0;
                  cur_last <= head[WIDTH];
                  ovf      <= head_ovf;
                  state    <= CONV;
               end
            end
            CONV: begin
               bin  <= sh[WIDTH-1:0];
               bcd  <= bcd_nx;
               iter <= iter + IW'(1);
               if (iter == LAST_ITER) begin
                  state    <= SHOW;
                  last_out <= cur_last;
                  seg1     <= ovf ? 4'hF : bcd_nx[3:0];
                  seg2     <= ovf ? 4'hF : bcd_nx[7:4];
                  seg3     <= ovf ? 4'hF : bcd_nx[11:8];
                  seg4     <= ovf ? 4'hF : bcd_nx[15:12];
                  seg5     <= ovf ? 4'hF : bcd_nx[19:16];
                  seg6     <= ovf ? 4'hF : bcd_nx[23:20];
               end
            end
            SHOW: begin
               if (next_in) begin
                  rd_ptr <= next_idx;
                  if (more) begin
                     bin      <= head[WIDTH-1:0];
                     bcd      <= '0;
                     iter     <= '0;
                     cur_last <= head[WIDTH];
                     ovf      <= head_ovf;
                     state    <= CONV;
                  end else begin
                     state    <= IDLE;
                     seg1     <= '0;
                     seg2     <= '0;
                     seg3     <= '0;
                     seg4     <= '0;
                     seg5     <= '0;
                     seg6     <= '0;
                     last_out <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
